pdm_pattern_player: RTL

Multi-channel pulse-density pattern player for the FSK transmitter datapath. It holds one shared, run-time-loadable 1-bit pattern memory and plays it out on NUM_CH independent channels. Each channel has its own enable and its own bit-period divider, so each tone channel can be paced separately. It is the parametrised successor of the fixed two-channel, fixed-100-bit PDM generator and drives the same downstream tone outputs.

---
 rtl/pdm_pattern_player.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pdm_pattern_player.sv
// pdm_pattern_player
//
// Multi-channel pulse-density pattern player. A single run-time-loadable
// 1-bit pattern memory is played out on NUM_CH independent channels. Each
// channel has its own run enable and its own clocks-per-bit divider. The
// channels share the pattern memory and the pattern length (pat_last).
//
// Ports
//   clk       : system clock, all logic on the rising edge
//   rst_n     : asynchronous active-low reset
//   ch_en     : per-channel run enable (level)
//   div       : per-channel clocks per output bit, channel c at [c*CNT_W +: CNT_W]
//               (0 behaves as 1)
//   pat_last  : index of the last pattern bit played (clamped to PAT_DEPTH-1)
//   wr_en     : pattern write strobe
//   wr_addr   : pattern write index (indices >= PAT_DEPTH are ignored)
//   wr_data   : pattern write bit
//   pdm_out   : registered PDM bit per channel
//   wrap      : one-cycle pulse per channel, aligned with bit pat_last on pdm_out

module pdm_pattern_player #(
    parameter int                   NUM_CH    = 2,
    parameter int                   PAT_DEPTH = 128,
    parameter int                   ADDR_W    = $clog2(PAT_DEPTH),
    parameter int                   CNT_W     = 32,
    parameter logic [PAT_DEPTH-1:0] PAT_INIT  = {PAT_DEPTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] div,
    input  logic [ADDR_W-1:0]       pat_last,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic                    wr_data,
    output logic [NUM_CH-1:0]       pdm_out,
    output logic [NUM_CH-1:0]       wrap
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_MAX = ADDR_W'(PAT_DEPTH - 1);

    logic [PAT_DEPTH-1:0] r_pat;
    state_t               r_state [NUM_CH];
    logic [ADDR_W-1:0]    r_idx   [NUM_CH];
    logic [CNT_W-1:0]     r_cnt   [NUM_CH];
    logic [NUM_CH-1:0]    r_pdm;
    logic [NUM_CH-1:0]    r_wrap;

    logic [ADDR_W-1:0]    w_last;
    logic                 w_wr_ok;
    logic [CNT_W-1:0]     w_thr     [NUM_CH];
    logic [CNT_W-1:0]     w_cur_cnt [NUM_CH];
    logic [ADDR_W-1:0]    w_cur_idx [NUM_CH];
    logic [NUM_CH-1:0]    w_strobe;
    logic [NUM_CH-1:0]    w_at_last;

    // Out-of-range lengths and write indices only occur for non-power-of-2 depths.
    assign w_last  = (32'(pat_last) >= 32'(PAT_DEPTH)) ? LP_LAST_MAX : pat_last;
    assign w_wr_ok = (32'(wr_addr) < 32'(PAT_DEPTH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] w_div;
        assign w_div = div[g*CNT_W +: CNT_W];

        // Strobe threshold is eff_div-1, with div==0 treated as 1.
        assign w_thr[g] = (w_div == '0) ? '0 : (w_div - CNT_W'(1));

        // An IDLE channel starts its first RUN edge from index 0, count 0.
        assign w_cur_cnt[g] = (r_state[g] == ST_RUN) ? r_cnt[g] : '0;
        assign w_cur_idx[g] = (r_state[g] == ST_RUN) ? r_idx[g] : '0;

        // ">=" so that lowering div or pat_last live takes effect at once.
        assign w_strobe[g]  = (w_cur_cnt[g] >= w_thr[g]);
        assign w_at_last[g] = (w_cur_idx[g] >= w_last);
    end

    // Pattern memory: reads below see the pre-write value on a shared edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= PAT_INIT;
        end else if (wr_en && w_wr_ok) begin
            r_pat[wr_addr] <= wr_data;
        end
    end

    // Per-channel IDLE/RUN state machines; disable has priority over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= ST_IDLE;
                r_idx[c]   <= '0;
                r_cnt[c]   <= '0;
            end
            r_pdm  <= '0;
            r_wrap <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!ch_en[c]) begin
                    r_state[c] <= ST_IDLE;
                    r_idx[c]   <= '0;
                    r_cnt[c]   <= '0;
                    r_pdm[c]   <= 1'b0;
                    r_wrap[c]  <= 1'b0;
                end else begin
                    r_state[c] <= ST_RUN;
                    if (w_strobe[c]) begin
                        r_pdm[c]  <= r_pat[w_cur_idx[c]];
                        r_cnt[c]  <= '0;
                        r_wrap[c] <= w_at_last[c];
                        r_idx[c]  <= w_at_last[c] ? '0 : (w_cur_idx[c] + ADDR_W'(1));
                    end else begin
                        r_cnt[c]  <= w_cur_cnt[c] + CNT_W'(1);
                        r_idx[c]  <= w_cur_idx[c];
                        r_wrap[c] <= 1'b0;
                    end
                end
            end
        end
    end

    assign pdm_out = r_pdm;
    assign wrap    = r_wrap;

endmodule
